// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and FSM encoding for the 8-digit BCD display path
package seg_pkg;
  localparam int DIGITS = 8;
  localparam int unsigned BCD_MAX = 99_999_999;
  localparam logic [3:0] DIGIT_ERR = 4'hF;
  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to any digit >= 5
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble binary to 8-digit BCD converter
// BIN_TO_BCD_OVF_SAT_EN: overflow shows 99999999 instead of FFFFFFFF
module bin_to_bcd #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic [7:0]            dp_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7:0]            dp_out,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);
  import seg_pkg::*;
  localparam int CW = $clog2(BIN_W + 1);
`ifdef BIN_TO_BCD_OVF_SAT_EN
  localparam logic [4*DIGITS-1:0] OVF_VAL = {DIGITS{4'h9}};
`else
  localparam logic [4*DIGITS-1:0] OVF_VAL = {DIGITS{DIGIT_ERR}};
`endif
  state_t state;
  logic [4*DIGITS-1:0] bcd, corr, bcd_nx;
  logic [BIN_W-1:0] bin;
  logic [CW-1:0] cnt;
  logic [7:0] dp_l;
  logic ovf_l;
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (.d(bcd[4*i +: 4]), .q(corr[4*i +: 4]));
  end
  assign bcd_nx = {corr[4*DIGITS-2:0], bin[BIN_W-1]};
  // outputs change only on the step that enters FINISH, so the display never sees partial digits
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      dp_out  <= '1;
      ovf     <= 1'b0;
      bcd     <= '0;
      bin     <= '0;
      cnt     <= '0;
      dp_l    <= '1;
      ovf_l   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= CONV;
          busy  <= 1'b1;
          bin   <= bin_in;
          dp_l  <= dp_in;
          ovf_l <= 32'(bin_in) > BCD_MAX;
          bcd   <= '0;
          cnt   <= CW'(BIN_W);
        end
        CONV: begin
          bcd <= bcd_nx;
          bin <= bin << 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state   <= FINISH;
            done    <= 1'b1;
            bcd_out <= ovf_l ? OVF_VAL : bcd_nx;
            dp_out  <= dp_l;
            ovf     <= ovf_l;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
